// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: shared FSM states, owner codes and defaults for the memory port arbiter
package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2,
    ST_TURN  = 2'd3
  } state_e;
  localparam logic [1:0] OWN_NONE = 2'b00;
  localparam logic [1:0] OWN_I    = 2'b01;
  localparam logic [1:0] OWN_D    = 2'b10;
  localparam int LINE_WORDS_DEF = 4;
endpackage

// File: rtl/mem_port_arbiter_burst_cnt.sv
// mem_burst_cnt: beat counter with load-length, increment-on-ready, last flag and sync clear
module mem_burst_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          clr_i,
  input  logic          load_i,
  input  logic [CW-1:0] len_m1_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_o
);
  logic [CW-1:0] cnt_q, cnt_d, lim_q, lim_d;
  assign cnt_o  = cnt_q;
  assign last_o = cnt_q == lim_q;
  // next count wraps to zero on the final beat so the next burst starts clean
  always_comb begin
    cnt_d = (clr_i | load_i) ? '0 : inc_i ? (last_o ? '0 : cnt_q + CW'(1)) : cnt_q;
    lim_d = clr_i ? '0 : load_i ? len_m1_i : lim_q;
  end
  // counter and burst-limit registers
  always_ff @(posedge clk) begin
    if (!clrn) begin
      cnt_q <= '0;
      lim_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lim_q <= lim_d;
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between I and D cache miss engines; MEM_ARB_ROUND_ROBIN_EN selects round-robin collision handling (default: D over I)
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int AW         = 32,
  parameter int DW         = 32
) (
  input  logic          clk,
  input  logic          clrn,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_ready,
  output logic [DW-1:0] i_data,
  output logic          i_last,
  input  logic          d_req,
  input  logic          d_we,
  input  logic          d_burst,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_ready,
  output logic [DW-1:0] d_data,
  output logic          d_last,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_st_data,
  output logic          mem_access,
  output logic          mem_write,
  input  logic [DW-1:0] mem_data,
  input  logic          mem_ready,
  output logic [1:0]    owner
);
  localparam int CW = $clog2(LINE_WORDS);
  localparam logic [AW-1:0] LINE_MASK = ~AW'(LINE_WORDS * 4 - 1);
  localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

  state_e        state_q;
  logic [AW-1:0] addr_q, grant_addr;
  logic [DW-1:0] wdata_q;
  logic          access_q, write_q;
  logic [1:0]    owner_q;
  logic [CW-1:0] cnt, len_m1;
  logic          cnt_last, pick_d, start, d_single, gnt_i, gnt_d, beat;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic i_served_q;
  // remember who won the last grant so a collision goes to the other side
  always_ff @(posedge clk) begin
    if (!clrn) i_served_q <= 1'b1;
    else if (start) i_served_q <= ~pick_d;
  end
  assign pick_d = d_req & (~i_req | i_served_q);
`else
  assign pick_d = d_req;
`endif

  // grant decode, beat routing and beat address generation
  always_comb begin
    start       = (state_q == ST_IDLE) & (i_req | d_req);
    d_single    = ~(d_burst & ~d_we);
    grant_addr  = pick_d ? (d_addr & (d_single ? WORD_MASK : LINE_MASK)) : (i_addr & LINE_MASK);
    len_m1      = (pick_d & d_single) ? '0 : CW'(LINE_WORDS - 1);
    gnt_i       = state_q == ST_GNT_I;
    gnt_d       = state_q == ST_GNT_D;
    beat        = mem_ready & (gnt_i | gnt_d);
    i_ready     = mem_ready & gnt_i;
    d_ready     = mem_ready & gnt_d;
    i_last      = i_ready & cnt_last;
    d_last      = d_ready & cnt_last;
    i_data      = mem_data;
    d_data      = mem_data;
    mem_a       = addr_q + AW'({cnt, 2'b00});
    mem_st_data = wdata_q;
    mem_access  = access_q;
    mem_write   = write_q;
    owner       = owner_q;
  end

  mem_burst_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .clrn     (clrn),
    .clr_i    (state_q == ST_TURN),
    .load_i   (start),
    .len_m1_i (len_m1),
    .inc_i    (beat),
    .cnt_o    (cnt),
    .last_o   (cnt_last)
  );

  // ownership FSM: latch request at grant, release on final beat, one idle turnaround cycle
  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      access_q <= 1'b0;
      write_q  <= 1'b0;
      owner_q  <= OWN_NONE;
    end else begin
      case (state_q)
        ST_IDLE: if (start) begin
          state_q  <= pick_d ? ST_GNT_D : ST_GNT_I;
          addr_q   <= grant_addr;
          access_q <= 1'b1;
          write_q  <= pick_d & d_we;
          owner_q  <= pick_d ? OWN_D : OWN_I;
          if (pick_d) wdata_q <= d_wdata;
        end
        ST_GNT_I, ST_GNT_D: if (beat & cnt_last) begin
          state_q  <= ST_TURN;
          access_q <= 1'b0;
          write_q  <= 1'b0;
          owner_q  <= OWN_NONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int LW = 4;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] dt;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0, d_burst = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_ready, i_last, d_ready, d_last, mem_access, mem_write;
  logic [31:0] i_data, d_data, mem_a, mem_st_data, mem_data;
  logic        mem_ready = 1'b0;
  logic [1:0]  owner;

  int n_tests = 0, n_fail = 0;
  int mode = 0, waits = 0, acc = 0, wcyc = 0, ovl = 0;
  logic [1:0] prev_own = 2'b00;
  beat_t ib[$], db[$];
  logic [31:0] wq[$];
  logic [1:0]  oq[$];

  mem_port_arbiter dut (
    .clk(clk), .clrn(clrn),
    .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_data(i_data), .i_last(i_last),
    .d_req(d_req), .d_we(d_we), .d_burst(d_burst), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_data(d_data), .d_last(d_last),
    .mem_a(mem_a), .mem_st_data(mem_st_data), .mem_access(mem_access), .mem_write(mem_write),
    .mem_data(mem_data), .mem_ready(mem_ready), .owner(owner)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] exp_addr(input logic [31:0] a, input logic full, input int k);
    return full ? ((a & ~32'(LW * 4 - 1)) + 32'(4 * k)) : (a & ~32'h3);
  endfunction

  assign mem_data = memfn(mem_a);

  // memory model: 0 always ready, 1 random, 2 ready after `waits` access cycles, else never
  always @(posedge clk) begin
    #1;
    acc = mem_access ? acc + 1 : 0;
    if (mode == 0) mem_ready = 1'b1;
    else if (mode == 1) mem_ready = 1'($urandom_range(0, 1));
    else if (mode == 2) mem_ready = acc > waits;
    else mem_ready = 1'b0;
  end

  // observe beats, store data, grant order and exclusivity
  always @(negedge clk) begin
    if (i_ready) ib.push_back('{mem_a, i_data, i_last});
    if (d_ready) db.push_back('{mem_a, d_data, d_last});
    if (d_ready && mem_write) wq.push_back(mem_st_data);
    if (mem_write) wcyc++;
    if ((i_ready && d_ready) || (i_ready && owner != 2'b01) || (d_ready && owner != 2'b10)) ovl++;
    if (owner != prev_own && owner != 2'b00) oq.push_back(owner);
    prev_own = owner;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_obs();
    ib.delete(); db.delete(); wq.delete(); oq.delete();
    wcyc = 0; ovl = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 clrn = 1'b0;
    @(posedge clk); #1 clrn = 1'b1;
  endtask

  task automatic i_txn(input logic [31:0] a);
    int n = 0;
    i_req = 1'b1; i_addr = a;
    @(negedge clk);
    while (i_last !== 1'b1 && n < 500) begin
      if (owner == 2'b01) i_addr = $urandom;
      n++;
      @(negedge clk);
    end
    if (n >= 500) begin
      n_tests++; n_fail++;
      $display("FAIL i_timeout: no i_last within %0d cycles", n);
    end
    @(posedge clk); #1 i_req = 1'b0;
  endtask

  task automatic d_txn(input logic we, input logic bu, input logic [31:0] a, input logic [31:0] wd);
    int n = 0;
    d_req = 1'b1; d_we = we; d_burst = bu; d_addr = a; d_wdata = wd;
    @(negedge clk);
    while (d_last !== 1'b1 && n < 500) begin
      if (owner == 2'b10) begin
        d_addr = $urandom; d_wdata = $urandom;
        d_we = 1'($urandom_range(0, 1)); d_burst = 1'($urandom_range(0, 1));
      end
      n++;
      @(negedge clk);
    end
    if (n >= 500) begin
      n_tests++; n_fail++;
      $display("FAIL d_timeout: no d_last within %0d cycles", n);
    end
    @(posedge clk); #1 d_req = 1'b0;
  endtask

  task automatic test_reset();
    mode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if ({mem_access, mem_write, owner, i_ready, i_last, d_ready, d_last} !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {mem_access, mem_write, owner, i_ready, i_last, d_ready, d_last});
    end
    n_tests++;
    if (mem_a !== 32'h0) begin n_fail++; $display("FAIL reset_mem_a: got %h want 0", mem_a); end
    n_tests++;
    if (mem_st_data !== 32'h0) begin n_fail++; $display("FAIL reset_st_data: got %h want 0", mem_st_data); end
    @(posedge clk); #1 clrn = 1'b1;
  endtask

  task automatic test_i_fill();
    mode = 0; clear_obs();
    i_txn(32'h0000_1234);
    @(negedge clk);
    n_tests++;
    if (mem_access !== 1'b0 || owner !== 2'b00) begin
      n_fail++; $display("FAIL i_fill_turn: access %b owner %b want 0 00", mem_access, owner);
    end
    n_tests++;
    if (ib.size() != LW || db.size() != 0) begin
      n_fail++; $display("FAIL i_fill_count: i beats %0d d beats %0d want %0d 0", ib.size(), db.size(), LW);
    end
    for (int k = 0; k < ib.size(); k++) begin
      logic [31:0] ea;
      ea = 32'h1230 + 32'(4 * k);
      n_tests++;
      if (ib[k] !== {ea, memfn(ea), 1'(k == LW - 1)}) begin
        n_fail++; $display("FAIL i_fill_beat%0d: got a=%h d=%h l=%b want a=%h d=%h l=%b",
                           k, ib[k].a, ib[k].dt, ib[k].last, ea, memfn(ea), k == LW - 1);
      end
    end
  endtask

  task automatic test_d_store();
    mode = 2; waits = 3; clear_obs();
    d_txn(1'b1, 1'b0, 32'h2008, 32'hDEAD_BEEF);
    @(negedge clk);
    n_tests++;
    if (wcyc != 4) begin n_fail++; $display("FAIL d_store_write_cycles: got %0d want 4", wcyc); end
    n_tests++;
    if (db.size() != 1 || db[0].a !== 32'h2008 || db[0].last !== 1'b1 || ib.size() != 0) begin
      n_fail++; $display("FAIL d_store_beat: d beats %0d i beats %0d a=%h want 1 0 a=00002008",
                         db.size(), ib.size(), db[0].a);
    end
    n_tests++;
    if (wq.size() != 1 || wq[0] !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL d_store_data: n=%0d got %h want deadbeef", wq.size(), wq[0]);
    end
    mode = 0;
  endtask

  task automatic test_collision();
    logic [5:0] exp_ord;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_ord = {2'b10, 2'b01, 2'b10};
`else
    exp_ord = {2'b10, 2'b10, 2'b01};
`endif
    mode = 0;
    do_reset();
    clear_obs();
    fork
      i_txn(32'h0000_4000);
      begin
        d_txn(1'b0, 1'b0, 32'h0000_5000, 32'h0);
        d_txn(1'b0, 1'b1, 32'h0000_6010, 32'h0);
      end
    join
    n_tests++;
    if (oq.size() != 3 || {oq[0], oq[1], oq[2]} !== exp_ord) begin
      n_fail++; $display("FAIL collision_order: n=%0d got %b%b%b want %b", oq.size(), oq[0], oq[1], oq[2], exp_ord);
    end
    n_tests++;
    if (ib.size() != LW || db.size() != 1 + LW || ovl != 0) begin
      n_fail++; $display("FAIL collision_beats: i %0d d %0d overlap %0d want %0d %0d 0", ib.size(), db.size(), ovl, LW, 1 + LW);
    end
  endtask

  task automatic test_req_in_turn();
    mode = 0; clear_obs();
    i_txn(32'h0000_7000);
    fork
      d_txn(1'b0, 1'b1, 32'h0000_8004, 32'h0);
      begin
        @(negedge clk);
        n_tests++;
        if (mem_access !== 1'b0 || owner !== 2'b00) begin
          n_fail++; $display("FAIL turn_idle: access %b owner %b want 0 00", mem_access, owner);
        end
      end
    join
    n_tests++;
    if (oq.size() != 2 || {oq[0], oq[1]} !== 4'b0110 || ovl != 0) begin
      n_fail++; $display("FAIL turn_order: n=%0d got %b%b overlap %0d want 0110 0", oq.size(), oq[0], oq[1], ovl);
    end
    n_tests++;
    if (db.size() != LW || db[0].a !== 32'h8000 || db[LW-1].a !== 32'h800C || db[LW-1].last !== 1'b1) begin
      n_fail++; $display("FAIL turn_d_burst: n=%0d first %h last %h want %0d 00008000 0000800c", db.size(), db[0].a, db[LW-1].a, LW);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    mode = 0; clear_obs();
    i_req = 1'b1; i_addr = 32'h0000_9008;
    @(negedge clk);
    while (ib.size() < 2 && n < 100) begin n++; @(negedge clk); end
    mode = 3; mem_ready = 1'b0; clrn = 1'b0;
    @(negedge clk);
    n_tests++;
    if (mem_access !== 1'b0 || owner !== 2'b00) begin
      n_fail++; $display("FAIL reset_mid_state: access %b owner %b want 0 00", mem_access, owner);
    end
    n_tests++;
    if (ib.size() != 2 || ib[0].last !== 1'b0 || ib[1].last !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_beats: got %0d beats want 2 without last", ib.size());
    end
    @(posedge clk); #1 clrn = 1'b1; i_req = 1'b0; mode = 0;
    clear_obs();
    i_txn(32'h0000_9008);
    n_tests++;
    if (ib.size() != LW || ib[0].a !== 32'h9000 || ib[LW-1].a !== 32'h900C || ib[LW-1].last !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_restart: n=%0d first %h last %h want %0d 00009000 0000900c", ib.size(), ib[0].a, ib[LW-1].a, LW);
    end
  endtask

  task automatic test_d_single();
    mode = 0; clear_obs();
    d_txn(1'b0, 1'b0, 32'h0000_3006, 32'h0);
    n_tests++;
    if (db.size() != 1 || db[0] !== {32'h3004, memfn(32'h3004), 1'b1}) begin
      n_fail++; $display("FAIL d_single: n=%0d got a=%h d=%h l=%b want a=00003004 d=%h l=1",
                         db.size(), db[0].a, db[0].dt, db[0].last, memfn(32'h3004));
    end
  endtask

  task automatic test_random();
    mode = 1;
    for (int it = 0; it < 24; it++) begin
      int kind, nb;
      logic [31:0] a, wd;
      logic full, bu;
      kind = $urandom_range(0, 3); a = $urandom; wd = $urandom;
      bu = 1'($urandom_range(0, 1));
      clear_obs();
      if (kind == 0) i_txn(a);
      else d_txn(kind == 3, kind == 3 ? bu : kind == 1, a, wd);
      full = kind <= 1;
      nb = full ? LW : 1;
      n_tests++;
      if ((kind == 0 ? ib.size() : db.size()) != nb || (kind == 0 ? db.size() : ib.size()) != 0 || ovl != 0) begin
        n_fail++; $display("FAIL rand%0d_count: kind %0d i %0d d %0d overlap %0d want %0d beats", it, kind, ib.size(), db.size(), ovl, nb);
      end else begin
        for (int k = 0; k < nb; k++) begin
          beat_t b;
          logic [31:0] ea;
          b = (kind == 0) ? ib[k] : db[k];
          ea = exp_addr(a, full, k);
          n_tests++;
          if (b.a !== ea || b.last !== 1'(k == nb - 1) || (kind != 3 && b.dt !== memfn(ea))) begin
            n_fail++; $display("FAIL rand%0d_beat%0d: kind %0d got a=%h d=%h l=%b want a=%h l=%b",
                               it, k, kind, b.a, b.dt, b.last, ea, k == nb - 1);
          end
        end
      end
      if (kind == 3) begin
        n_tests++;
        if (wq.size() != 1 || wq[0] !== wd) begin
          n_fail++; $display("FAIL rand%0d_store: n=%0d got %h want %h", it, wq.size(), wq[0], wd);
        end
      end
    end
    mode = 0;
  endtask

  initial begin
    test_reset();
    test_i_fill();
    test_d_store();
    test_collision();
    test_req_in_turn();
    test_reset_mid();
    test_d_single();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
